// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes four of the six BCD clock digits onto a
// 4-digit common-anode seven-segment display (active-low an/seg/dp).
// Displayed data comes from a per-frame snapshot, so a frame never mixes old
// and new digits. The edited field blinks, and the decimal point of the third
// digit from the right acts as a 1 s colon.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN. When it is defined, a
// zero hours-tens digit is blanked on the HH:MM page.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       sw,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic [1:0] pos,
  input  logic       edit_en,
  input  logic       page,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = 7'b0111111;
    endcase
    return r;
  endfunction

  logic [RW-1:0] refresh_cnt_r;
  logic [1:0]    idx_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_phase_r;

  logic [3:0] snap_s1_r;
  logic [3:0] snap_s2_r;
  logic [3:0] snap_m1_r;
  logic [3:0] snap_m2_r;
  logic [3:0] snap_h1_r;
  logic [3:0] snap_h2_r;
  logic       snap_page_r;

  logic [3:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;

  logic       refresh_tc_s;
  logic       frame_tc_s;
  logic       blink_tc_s;
  logic [3:0] digit_s;
  logic       field_blank_s;
  logic       lead_blank_s;
  logic [3:0] an_next_s;
  logic [6:0] seg_next_s;
  logic       dp_next_s;

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

  // Terminal-count strobes for the digit slot, the whole frame and the blink phase.
  always_comb begin
    refresh_tc_s = (refresh_cnt_r == REFRESH_LAST);
    frame_tc_s   = refresh_tc_s && (idx_r == 2'd3);
    blink_tc_s   = (blink_cnt_r == BLINK_LAST);
  end

  // Slot timer and digit index: the index advances once per slot.
  always_ff @(posedge clk) begin
    if (sw) begin
      refresh_cnt_r <= '0;
      idx_r         <= 2'd0;
    end else if (refresh_tc_s) begin
      refresh_cnt_r <= '0;
      idx_r         <= idx_r + 2'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1);
    end
  end

  // Frame snapshot: captured as the index wraps 3->0 so the new frame is coherent.
  always_ff @(posedge clk) begin
    if (sw) begin
      snap_s1_r   <= 4'd0;
      snap_s2_r   <= 4'd0;
      snap_m1_r   <= 4'd0;
      snap_m2_r   <= 4'd0;
      snap_h1_r   <= 4'd0;
      snap_h2_r   <= 4'd0;
      snap_page_r <= 1'b0;
    end else if (frame_tc_s) begin
      snap_s1_r   <= s1;
      snap_s2_r   <= s2;
      snap_m1_r   <= m1;
      snap_m2_r   <= m2;
      snap_h1_r   <= h1;
      snap_h2_r   <= h2;
      snap_page_r <= page;
    end
  end

  // Free-running blink timer; the phase starts visible and toggles at terminal count.
  always_ff @(posedge clk) begin
    if (sw) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
    end else if (blink_tc_s) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BW'(1);
    end
  end

  // Select the digit for the active slot and work out the next an/seg/dp values.
  always_comb begin
    digit_s       = 4'd0;
    field_blank_s = 1'b0;
    lead_blank_s  = 1'b0;
    an_next_s     = 4'b1111;
    seg_next_s    = SEG_BLANK;
    dp_next_s     = 1'b1;

    case ({snap_page_r, idx_r})
      3'b0_00: digit_s = snap_m1_r;
      3'b0_01: digit_s = snap_m2_r;
      3'b0_10: digit_s = snap_h1_r;
      3'b0_11: digit_s = snap_h2_r;
      3'b1_00: digit_s = snap_s1_r;
      3'b1_01: digit_s = snap_s2_r;
      3'b1_10: digit_s = snap_m1_r;
      3'b1_11: digit_s = snap_m2_r;
      default: digit_s = 4'd0;
    endcase

    // Hours sit in slots 3/2 on HH:MM; minutes in 1/0 on HH:MM and 3/2 on MM:SS.
    if (edit_en && !blink_phase_r) begin
      if (!snap_page_r) begin
        case (pos)
          2'd1:    field_blank_s = idx_r[1];
          2'd2:    field_blank_s = ~idx_r[1];
          default: field_blank_s = 1'b0;
        endcase
      end else begin
        case (pos)
          2'd2:    field_blank_s = idx_r[1];
          default: field_blank_s = 1'b0;
        endcase
      end
    end else begin
      field_blank_s = 1'b0;
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    lead_blank_s = !snap_page_r && (idx_r == 2'd3) && (snap_h2_r == 4'd0);
`else
    lead_blank_s = 1'b0;
`endif

    case (idx_r)
      2'd0:    an_next_s = 4'b1110;
      2'd1:    an_next_s = 4'b1101;
      2'd2:    an_next_s = 4'b1011;
      2'd3:    an_next_s = 4'b0111;
      default: an_next_s = 4'b1111;
    endcase

    if (field_blank_s || lead_blank_s) begin
      seg_next_s = SEG_BLANK;
    end else begin
      seg_next_s = seg_decode(digit_s);
    end

    // Colon follows the snapshot seconds LSB, giving 1 s on / 1 s off.
    if ((idx_r == 2'd2) && !snap_s1_r[0]) begin
      dp_next_s = 1'b0;
    end else begin
      dp_next_s = 1'b1;
    end
  end

  // Output registers: pins follow the index one cycle after it changes.
  always_ff @(posedge clk) begin
    if (sw) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed test of seven_seg_scanner with REFRESH_DIV=4
// and BLINK_DIV=16, so one frame is 16 cycles and the blink phase toggles once
// per frame (even frames after reset visible, odd frames blanking).
// Snapshot inputs changed during frame f show up in frame f+1; live inputs
// (edit_en, pos) changed between frames apply immediately.
module tb_seven_seg_scanner;

  localparam int RD = 4;
  localparam int BD = 16;

  localparam logic [6:0] D0    = 7'b1000000;
  localparam logic [6:0] D1    = 7'b1111001;
  localparam logic [6:0] D2    = 7'b0100100;
  localparam logic [6:0] D4    = 7'b0011001;
  localparam logic [6:0] D5    = 7'b0010010;
  localparam logic [6:0] D7    = 7'b1111000;
  localparam logic [6:0] D8    = 7'b0000000;
  localparam logic [6:0] D9    = 7'b0010000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] H2ZERO = BLANK;
`else
  localparam logic [6:0] H2ZERO = D0;
`endif

  logic       clk = 1'b0;
  logic       sw;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic [1:0] pos;
  logic       edit_en;
  logic       page;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_seg [4];
  logic       exp_dp2;
  string      cur_tag;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .sw(sw),
    .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
    .pos(pos), .edit_en(edit_en), .page(page),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3, input logic dp2);
    cur_tag    = tag;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    exp_dp2    = dp2;
  endtask

  // Step through slots first..last, checking every cycle of each slot.
  task automatic run_slots(input int first, input int last);
    logic [3:0] a;
    logic       d;
    for (int k = first; k <= last; k++) begin
      for (int c = 0; c < RD; c++) begin
        step();
        a = ~(4'b0001 << k);
        d = (k == 2) ? exp_dp2 : 1'b1;
        check_eq($sformatf("%s an s%0d c%0d", cur_tag, k, c), {4'b0000, an}, {4'b0000, a});
        check_eq($sformatf("%s seg s%0d c%0d", cur_tag, k, c), {1'b0, seg}, {1'b0, exp_seg[k]});
        check_eq($sformatf("%s dp s%0d c%0d", cur_tag, k, c), {7'b0000000, dp}, {7'b0000000, d});
      end
    end
  endtask

  initial begin
    sw = 1'b1;
    h2 = 4'd1; h1 = 4'd2; m2 = 4'd5; m1 = 4'd8; s2 = 4'd0; s1 = 4'd4;
    pos = 2'd0; edit_en = 1'b0; page = 1'b0;

    for (int i = 0; i < 3; i++) step();
    check_eq("reset an", {4'b0000, an}, 8'h0F);
    check_eq("reset seg", {1'b0, seg}, 8'h7F);
    check_eq("reset dp", {7'b0000000, dp}, 8'h01);
    sw = 1'b0;

    // F0: reset snapshot is all zeros
    set_exp("f0 zeros", D0, D0, D0, D0, 1'b0);
    run_slots(0, 3);
    // F1: 12:58, blink phase 0 but no edit
    set_exp("f1 page0", D8, D5, D2, D1, 1'b0);
    run_slots(0, 3);
    // F2: m1 changes mid-frame, current frame unaffected
    set_exp("f2 snap", D8, D5, D2, D1, 1'b0);
    run_slots(0, 1);
    m1 = 4'd9;
    run_slots(2, 3);
    // F3: new m1 visible; page switches mid-frame
    set_exp("f3 m1new", D9, D5, D2, D1, 1'b0);
    run_slots(0, 1);
    page = 1'b1;
    run_slots(2, 3);
    // F4: MM:SS = 59:04
    set_exp("f4 page1", D4, D0, D9, D5, 1'b0);
    run_slots(0, 1);
    page = 1'b0;
    run_slots(2, 3);
    edit_en = 1'b1; pos = 2'd2;
    // F5: minutes blank on HH:MM
    set_exp("f5 blink", BLANK, BLANK, D2, D1, 1'b0);
    run_slots(0, 3);
    // F6: visible phase
    set_exp("f6 visible", D9, D5, D2, D1, 1'b0);
    run_slots(0, 1);
    page = 1'b1;
    run_slots(2, 3);
    pos = 2'd1;
    // F7: hours edit on MM:SS blanks nothing
    set_exp("f7 pos1p1", D4, D0, D9, D5, 1'b0);
    run_slots(0, 3);
    pos = 2'd2;
    // F8: visible phase, page 1
    set_exp("f8 visible", D4, D0, D9, D5, 1'b0);
    run_slots(0, 3);
    // F9: minutes edit on MM:SS blanks slots 3/2
    set_exp("f9 pos2p1", D4, D0, BLANK, BLANK, 1'b0);
    run_slots(0, 1);
    page = 1'b0; m1 = 4'hC; s1 = 4'd5;
    run_slots(2, 3);
    edit_en = 1'b0;
    // F10: invalid m1 shows dash, odd seconds clear the colon
    set_exp("f10 invalid", DASH, D5, D2, D1, 1'b1);
    run_slots(0, 1);
    h2 = 4'd0; h1 = 4'd7; s1 = 4'd4;
    run_slots(2, 3);
    // F11: zero hours tens
    set_exp("f11 h2zero", DASH, D5, D7, H2ZERO, 1'b0);
    run_slots(0, 1);
    page = 1'b1; m2 = 4'd0;
    run_slots(2, 3);
    pos = 2'd1;
    // F12: page 1 with m2=0 always shows 0
    set_exp("f12 m2zero", D4, D0, DASH, D0, 1'b0);
    run_slots(0, 1);
    page = 1'b0;
    run_slots(2, 3);
    edit_en = 1'b1;
    // F13: hours edit on HH:MM blanks slots 3/2
    set_exp("f13 pos1p0", DASH, D0, BLANK, BLANK, 1'b0);
    run_slots(0, 3);
    // F14: reset in the middle of a frame
    set_exp("f14 pre", DASH, D0, D7, H2ZERO, 1'b0);
    run_slots(0, 1);
    sw = 1'b1;
    step();
    check_eq("midreset an", {4'b0000, an}, 8'h0F);
    check_eq("midreset seg", {1'b0, seg}, 8'h7F);
    check_eq("midreset dp", {7'b0000000, dp}, 8'h01);
    sw = 1'b0;
    set_exp("post reset", D0, D0, D0, D0, 1'b0);
    run_slots(0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream display stage for the digital clock core.
- Takes the six BCD time digits (h2 h1 : m2 m1 : s2 s1) and the edit-field pointer `pos`, and time-multiplexes four of the digits onto the board's 4-digit common-anode seven-segment display.
- Provides tear-free frame snapshots, a colon indicator, and blinking of the field being edited.
- Instantiated next to the clock core at top level. Drives `an`, `seg` and `dp` pins directly.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Gives 1 kHz per digit at 100 MHz. Legal values ≥ 2.
- BLINK_DIV, 25000000: clk cycles per blink-phase toggle. Legal values ≥ 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- sw  input  1  synchronous active-high reset. Same switch that clears the clock core.
- s1, s2, m1, m2, h1, h2  input  4 each  BCD digits from the clock core (ones, tens).
- pos  input  2  edit field from the clock core: 1 = hour, 2 = minute, other values = none.
- edit_en  input  1  1 = blink the field selected by `pos`.
- page  input  1  0 = show HH:MM, 1 = show MM:SS.
- an  output  4  digit enables, active-low. an[3] is the leftmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low. Used as the colon.

Behaviour:
- Reset (sw=1 at posedge): an=4'b1111, seg=7'b1111111, dp=1.
  - Refresh counter, digit index, blink counter and snapshot registers all cleared to 0.
  - Blink phase set to 1 (visible).
  - Reset overrides all other activity, including mid-frame.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. Width is $clog2(REFRESH_DIV).
  - At terminal count, the digit index advances 0→1→2→3→0.
- Snapshot: on the terminal count where the index goes 3→0, register s1..h2 and `page`.
  - All displayed data comes from the snapshot, so no frame mixes old and new digits.
  - `page` and digit changes therefore become visible at the next frame boundary.
- Blink counter: counts 0..BLINK_DIV-1. At terminal count, the blink phase toggles.
  - The counter runs regardless of edit_en.
  - edit_en is sampled live, not snapshotted.
- Digit mapping for page 0 (HH:MM): idx0=m1, idx1=m2, idx2=h1, idx3=h2.
- Digit mapping for page 1 (MM:SS): idx0=s1, idx1=s2, idx2=m1, idx3=m2.
- Outputs are registered.
  - an, seg and dp reflect a new index exactly 1 cycle after the index register changes.
  - For the active index, an has a single 0 at bit idx.
- Decode table (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10–15 decode to a dash, 0111111.
- Blink blanking: when edit_en=1 and blink phase=0, seg=1111111 for the digits of the edited field. an still scans normally.
  - Page 0: pos=1 blanks idx3 and idx2; pos=2 blanks idx1 and idx0.
  - Page 1: pos=2 blanks idx3 and idx2; pos=1 blanks nothing, since hours are not shown.
  - pos=0 or pos=3 blanks nothing.
- Colon: dp=0 only at idx2, and only when the snapshot s1[0]==0. Otherwise dp=1. This gives a 1 s on/off colon.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: in page 0, when snapshot h2==0, idx3 shows seg=1111111.
  - The blink rule still applies on top.
  - Page 1 is unaffected.
- Undefined: h2==0 displays as "0" (1000000).

Test Plan:
- Reset: hold sw=1 for 3 cycles with REFRESH_DIV=4, BLINK_DIV=16 → an=1111, seg=1111111, dp=1. First frame after release shows zeros; an sequence is 1110, 1101, 1011, 0111, changing every 4 cycles.
- Page 0 with digits h2=1, h1=2, m2=5, m1=8, s1=4 and no edit → per frame the bench sees:
  - idx0 seg=0000000 (8)
  - idx1 seg=0010010 (5)
  - idx2 seg=0100100 (2) with dp=0
  - idx3 seg=1111001 (1)
- Snapshot: change m1 from 8 to 9 while idx=1 → idx0 still shows 8 until the 3→0 boundary, then shows 0010000. Switching page to 1 mid-frame also takes effect only at the next frame.
- Blink: edit_en=1, pos=2, page 0 → idx0 and idx1 alternate blank/visible every 16 cycles; idx2 and idx3 are never blank. With pos=1 on page 1, no digit blanks.
- Invalid digit: m1=4'hC → the corresponding slot shows 0111111. s1=5 → dp=1 at idx2.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined and h2=0, h1=7 on page 0 → idx3 seg=1111111, idx2 seg=1111000. On page 1 with m2=0, idx3 shows 1000000.
